// File: rtl/rpn_evaluator_pkg.sv
// Shared operator codes, error codes and FSM state type for the RPN evaluation path.
// These are the calculator's internal constants, kept here so every file imports one definition.
package rpn_evaluator_pkg;

  localparam int CO_N = 4;

  localparam logic [CO_N-1:0] CO_OK = 4'd0;
  localparam logic [CO_N-1:0] CO_AD = 4'd1;
  localparam logic [CO_N-1:0] CO_SB = 4'd2;
  localparam logic [CO_N-1:0] CO_MU = 4'd3;
  localparam logic [CO_N-1:0] CO_DI = 4'd4;
  localparam logic [CO_N-1:0] CO_NS = 4'd5;
  localparam logic [CO_N-1:0] CO_PS = 4'd6;
  localparam logic [CO_N-1:0] CO_LP = 4'd7;
  localparam logic [CO_N-1:0] CO_RP = 4'd8;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_UNDF = 3'd1;
  localparam logic [2:0] ERR_SOVF = 3'd2;
  localparam logic [2:0] ERR_DIV0 = 3'd3;
  localparam logic [2:0] ERR_BTOK = 3'd4;
  localparam logic [2:0] ERR_AOVF = 3'd5;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_DIV    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_EMIT   = 2'd3
  } state_t;

endpackage

// File: rtl/rpn_divider.sv
// Signed restoring divider: one quotient bit per cycle, W cycles per divide, remainder dropped.
// done pulses in the last busy cycle with quot/ovf valid combinationally in that same cycle.
module rpn_divider
  import rpn_evaluator_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quot,
  output logic         ovf
);

  localparam int CW = $clog2(W + 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W-1:0]  quo_q, quo_d;
  logic          neg_q, neg_d;

  logic [W:0]    shifted;
  logic [W:0]    trial;
  logic          qbit;
  logic [W-1:0]  quo_next;
  logic [W-1:0]  a_mag, b_mag;

  always_comb begin
    a_mag    = a[W-1] ? (~a + 1'b1) : a;
    b_mag    = b[W-1] ? (~b + 1'b1) : b;
    shifted  = {rem_q, dvd_q[W-1]};
    trial    = shifted - {1'b0, dvs_q};
    qbit     = ~trial[W];
    quo_next = {quo_q[W-2:0], qbit};

    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    neg_d  = neg_q;

    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CW'(W);
      rem_d  = '0;
      dvd_d  = a_mag;
      dvs_d  = b_mag;
      quo_d  = '0;
      neg_d  = a[W-1] ^ b[W-1];
    end else if (busy_q) begin
      rem_d = qbit ? trial[W-1:0] : shifted[W-1:0];
      dvd_d = dvd_q << 1;
      quo_d = quo_next;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(1));
  assign quot = neg_q ? (~quo_next + 1'b1) : quo_next;
  // A positive quotient with the top bit set only arises from most-negative / -1.
  assign ovf  = !neg_q && quo_next[W-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      neg_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
      neg_q  <= neg_d;
    end
  end

endmodule

// File: rtl/rpn_evaluator.sv
// Postfix token evaluator: operand stack, sticky error, result handshake; divides run in rpn_divider.
// Define RPN_OVF_EN to report signed arithmetic overflow as error 5 instead of wrapping.
module rpn_evaluator
  import rpn_evaluator_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_op,
  input  logic [CO_N-1:0] in_op,
  input  logic [W-1:0]    in_num,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_value,
  output logic [2:0]      out_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

`ifdef RPN_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  state_t        state_q, state_d;
  logic [W-1:0]  stack_q [DEPTH];
  logic [W-1:0]  stack_d [DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic [2:0]    err_q, err_d;
  logic [W-1:0]  oval_q, oval_d;
  logic [2:0]    oerr_q, oerr_d;

  logic [AW-1:0]  push_idx, top_idx, sec_idx;
  logic [W-1:0]   opa, opb, alu;
  logic [W-1:0]   sum, diff;
  logic [2*W-1:0] prod;
  logic           alu_ovf;
  logic           has1, has2, full;
  logic [2:0]     tok_err;
  logic           div_start, div_busy, div_done, div_ovf;
  logic [W-1:0]   div_quot;

  assign push_idx = depth_q[AW-1:0];
  assign top_idx  = depth_q[AW-1:0] - AW'(1);
  assign sec_idx  = depth_q[AW-1:0] - AW'(2);
  assign opb      = stack_q[top_idx];
  assign opa      = stack_q[sec_idx];
  assign has1     = depth_q != '0;
  assign has2     = depth_q >= DW'(2);
  assign full     = depth_q == DW'(DEPTH);

  assign sum  = opa + opb;
  assign diff = opa - opb;
  assign prod = $signed({{W{opa[W-1]}}, opa}) * $signed({{W{opb[W-1]}}, opb});

  always_comb begin
    alu     = sum;
    alu_ovf = (opa[W-1] == opb[W-1]) && (sum[W-1] != opa[W-1]);
    if (in_op == CO_SB) begin
      alu     = diff;
      alu_ovf = (opa[W-1] != opb[W-1]) && (diff[W-1] != opa[W-1]);
    end else if (in_op == CO_MU) begin
      alu     = prod[W-1:0];
      alu_ovf = prod[2*W-1:W] != {W{prod[W-1]}};
    end
  end

  rpn_divider #(.W(W)) u_div (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (div_start),
    .a       (opa),
    .b       (opb),
    .busy    (div_busy),
    .done    (div_done),
    .quot    (div_quot),
    .ovf     (div_ovf)
  );

  assign in_ready  = (state_q == ST_ACCEPT) || (state_q == ST_DRAIN);
  assign out_valid = (state_q == ST_EMIT);
  assign out_value = oval_q;
  assign out_err   = oerr_q;

  always_comb begin
    state_d   = state_q;
    stack_d   = stack_q;
    depth_d   = depth_q;
    err_d     = err_q;
    oval_d    = oval_q;
    oerr_d    = oerr_q;
    tok_err   = ERR_NONE;
    div_start = 1'b0;

    case (state_q)
      ST_ACCEPT: begin
        if (in_valid) begin
          if (!in_is_op) begin
            if (full) tok_err = ERR_SOVF;
            else begin
              stack_d[push_idx] = in_num;
              depth_d           = depth_q + DW'(1);
            end
          end else begin
            case (in_op)
              CO_AD, CO_SB, CO_MU: begin
                if (!has2) tok_err = ERR_UNDF;
                else if (OVF_EN && alu_ovf) tok_err = ERR_AOVF;
                else begin
                  stack_d[sec_idx] = alu;
                  depth_d          = depth_q - DW'(1);
                end
              end
              CO_PS: if (!has1) tok_err = ERR_UNDF;
              CO_NS: begin
                if (!has1) tok_err = ERR_UNDF;
                else if (OVF_EN && opb == MIN_VAL) tok_err = ERR_AOVF;
                else stack_d[top_idx] = ~opb + 1'b1;
              end
              CO_DI: begin
                if (!has2) tok_err = ERR_UNDF;
                else if (opb == '0) tok_err = ERR_DIV0;
                else if (!div_busy) begin
                  div_start = 1'b1;
                  state_d   = ST_DIV;
                end
              end
              CO_OK: begin
                depth_d = '0;
                state_d = ST_EMIT;
                if (depth_q == DW'(1)) begin
                  oval_d = opb;
                  oerr_d = ERR_NONE;
                end else begin
                  oval_d = '0;
                  oerr_d = has1 ? ERR_BTOK : ERR_UNDF;
                end
              end
              default: tok_err = ERR_BTOK;
            endcase
          end
          if (tok_err != ERR_NONE) begin
            err_d   = tok_err;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DIV: begin
        // Operands stay on the stack while dividing; the quotient replaces them at the end.
        if (div_done) begin
          if (OVF_EN && div_ovf) begin
            err_d   = ERR_AOVF;
            state_d = ST_DRAIN;
          end else begin
            stack_d[sec_idx] = div_quot;
            depth_d          = depth_q - DW'(1);
            state_d          = ST_ACCEPT;
          end
        end
      end
      ST_DRAIN: begin
        if (in_valid && in_is_op && in_op == CO_OK) begin
          oval_d  = '0;
          oerr_d  = err_q;
          depth_d = '0;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          err_d   = ERR_NONE;
          state_d = ST_ACCEPT;
        end
      end
      default: state_d = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ACCEPT;
      depth_q <= '0;
      err_q   <= ERR_NONE;
      oval_q  <= '0;
      oerr_q  <= ERR_NONE;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      oval_q  <= oval_d;
      oerr_q  <= oerr_d;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

endmodule

// File: tb/tb_rpn_evaluator.sv
// Scoreboard bench for rpn_evaluator: directed scenarios plus random expressions vs a queue-based model.
module tb_rpn_evaluator;
  import rpn_evaluator_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 8;

`ifdef RPN_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    bit         is_op;
    logic [3:0] op;
    int         num;
  } tok_t;

  logic            clock = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_is_op = 1'b0;
  logic [CO_N-1:0] in_op = '0;
  logic [W-1:0]    in_num = '0;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_value;
  logic [2:0]      out_err;

  int checks = 0;
  int errors = 0;
  int         exp_v[$];
  logic [2:0] exp_e[$];
  bit bp_rand = 1'b0;
  bit rdy_hold = 1'b0;

  rpn_evaluator #(.W(W), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset_n   (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_is_op  (in_is_op),
    .in_op     (in_op),
    .in_num    (in_num),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_err   (out_err)
  );

  always #5 clock = ~clock;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      out_ready = bp_rand ? 1'($urandom_range(0, 1)) : !rdy_hold;
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic tok_t N(input int v);
    tok_t t;
    t.is_op = 1'b0; t.op = CO_OK; t.num = v;
    return t;
  endfunction

  function automatic tok_t O(input logic [3:0] op);
    tok_t t;
    t.is_op = 1'b1; t.op = op; t.num = 0;
    return t;
  endfunction

  // Reference: evaluate the token list with a plain integer stack and 64-bit arithmetic.
  function automatic void model(input tok_t q[$], output int val, output logic [2:0] err);
    int st[$];
    longint r;
    int a, b;
    err = 3'd0;
    val = 0;
    foreach (q[i]) begin
      if (q[i].is_op && q[i].op == CO_OK) break;
      if (err != 3'd0) continue;
      if (!q[i].is_op) begin
        if (st.size() == DEPTH) err = 3'd2;
        else st.push_back(q[i].num);
      end else begin
        case (q[i].op)
          CO_AD, CO_SB, CO_MU, CO_DI: begin
            if (st.size() < 2) err = 3'd1;
            else begin
              b = st.pop_back();
              a = st.pop_back();
              if (q[i].op == CO_DI && b == 0) err = 3'd3;
              else begin
                case (q[i].op)
                  CO_AD:   r = longint'(a) + longint'(b);
                  CO_SB:   r = longint'(a) - longint'(b);
                  CO_MU:   r = longint'(a) * longint'(b);
                  default: r = longint'(a) / longint'(b);
                endcase
                if (OVF_EN && (r > 64'sd2147483647 || r < -64'sd2147483648)) err = 3'd5;
                else st.push_back(int'(r));
              end
            end
          end
          CO_PS: if (st.size() < 1) err = 3'd1;
          CO_NS: begin
            if (st.size() < 1) err = 3'd1;
            else begin
              a = st.pop_back();
              r = -longint'(a);
              if (OVF_EN && r > 64'sd2147483647) err = 3'd5;
              else st.push_back(int'(r));
            end
          end
          default: err = 3'd4;
        endcase
      end
    end
    if (err == 3'd0) begin
      if (st.size() == 1) val = st[0];
      else if (st.size() == 0) err = 3'd1;
      else err = 3'd4;
    end
  endfunction

  task automatic expect_expr(input tok_t q[$]);
    int v;
    logic [2:0] e;
    model(q, v, e);
    exp_v.push_back(v);
    exp_e.push_back(e);
  endtask

  task automatic send(input tok_t t);
    int n = 0;
    in_valid = 1'b1;
    in_is_op = t.is_op;
    in_op    = t.op;
    in_num   = t.num;
    while (!in_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL in_ready_wait actual=0 expected=1 t=%0t", $time);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic run_expr(input tok_t q[$]);
    expect_expr(q);
    foreach (q[i]) send(q[i]);
    chk("ok_latency", W'(out_valid), W'(1));
  endtask

  // Monitor: pops the scoreboard on every accepted result and checks hold-while-stalled.
  initial begin
    bit stalled = 1'b0;
    logic [W-1:0] held_v;
    logic [2:0]   held_e;
    int ev;
    logic [2:0] ee;
    forever begin
      @(negedge clock);
      if (!rst_n || !out_valid) stalled = 1'b0;
      else begin
        chk("emit_in_ready", W'(in_ready), W'(0));
        if (stalled) begin
          chk("hold_value", out_value, held_v);
          chk("hold_err", W'(out_err), W'(held_e));
        end
        if (!out_ready) begin
          stalled = 1'b1;
          held_v  = out_value;
          held_e  = out_err;
        end else begin
          stalled = 1'b0;
          if (exp_v.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result actual=%0h expected=none", out_value);
          end else begin
            ev = exp_v.pop_front();
            ee = exp_e.pop_front();
            chk("result_err", W'(out_err), W'(ee));
            chk("result_value", out_value, ev);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic rand_expr();
    tok_t q[$];
    int n, d, k, s, v;
    n = $urandom_range(1, 14);
    d = 0;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 99);
      if (k < 5) q.push_back(O(4'($urandom_range(7, 15))));
      else if ((d < 2 && k < 90) || k < 45) begin
        s = $urandom_range(0, 5);
        case (s)
          0: v = int'($urandom);
          1: v = int'($urandom_range(0, 40)) - 20;
          2: v = 0;
          3: v = 32'sh7FFFFFFF;
          4: v = 32'sh80000000;
          default: v = -1;
        endcase
        q.push_back(N(v));
        d++;
      end else begin
        s = $urandom_range(0, 5);
        case (s)
          0: q.push_back(O(CO_AD));
          1: q.push_back(O(CO_SB));
          2: q.push_back(O(CO_MU));
          3: q.push_back(O(CO_DI));
          4: q.push_back(O(CO_NS));
          default: q.push_back(O(CO_PS));
        endcase
        if (s < 4) d--;
      end
    end
    q.push_back(O(CO_OK));
    run_expr(q);
  endtask

  initial begin
    tok_t q[$];
    int n;
    #2;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_value", out_value, '0);
    chk("rst_out_err", W'(out_err), W'(0));
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);

    run_expr('{N(3), N(4), O(CO_AD), N(2), O(CO_MU), O(CO_OK)});

    q = '{N(7), N(-2), O(CO_DI), O(CO_OK)};
    expect_expr(q);
    for (int i = 0; i < 3; i++) send(q[i]);
    n = 0;
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clock);
    end
    chk("div_busy_cycles", W'(n), W'(W));
    send(q[3]);
    chk("ok_latency", W'(out_valid), W'(1));

    run_expr('{N(5), N(0), O(CO_DI), N(9), O(CO_AD), O(CO_OK)});
    q = {};
    for (int i = 0; i < 9; i++) q.push_back(N(i + 1));
    q.push_back(O(CO_OK));
    run_expr(q);
    run_expr('{N(1), O(CO_OK)});

    rdy_hold = 1'b1;
    run_expr('{N(1), N(2), O(CO_OK)});
    repeat (5) begin
      @(negedge clock);
      chk("bp_valid", W'(out_valid), W'(1));
    end
    rdy_hold = 1'b0;

    run_expr('{O(CO_AD), O(CO_OK)});
    run_expr('{N(32'sh7FFFFFFF), N(1), O(CO_AD), O(CO_OK)});
    run_expr('{N(32'sh80000000), N(-1), O(CO_DI), O(CO_OK)});
    run_expr('{N(32'sh80000000), O(CO_NS), O(CO_OK)});
    run_expr('{N(65536), N(65536), O(CO_MU), O(CO_OK)});
    run_expr('{N(-7), N(2), O(CO_DI), N(1), O(CO_LP), O(CO_OK)});

    send(N(7));
    send(N(-2));
    send(O(CO_DI));
    repeat (9) @(negedge clock);
    rst_n = 1'b0;
    #1;
    chk("div_rst_valid", W'(out_valid), W'(0));
    @(negedge clock);
    chk("div_rst_ready", W'(in_ready), W'(1));
    chk("div_rst_value", out_value, '0);
    rst_n = 1'b1;
    @(negedge clock);
    run_expr('{N(2), O(CO_NS), O(CO_OK)});

    for (int i = 0; i < 160; i++) begin
      bp_rand = (i >= 80);
      rand_expr();
    end

    n = 0;
    while (exp_v.size() != 0 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    bp_rand = 1'b0;
    chk("scoreboard_empty", W'(exp_v.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
